alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Micro-sequencer/ALU stage that sits directly upstream of the 8-entry register bank.
- Drives the bank's write-select, read-select, bus output-enable and write data, and consumes the bank's tri-state read bus.
- Executes one 3-operand register instruction (rd <= rs1 op rs2) per accepted request using a fixed 4-cycle FSM.
- Register 0 of the bank is hardwired zero and its write enable is tied off, so write index 0 is the idle/no-write code.

Parameters:
DATA_W, 8, datapath/bus width; must match the bank width
IDX_W, 3, register index width (8 registers)

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  reset, asynchronous, active-high
instr_valid  input  1  instruction request valid
instr_ready  output  1  sequencer can accept an instruction
instr_op  input  3  opcode
instr_rd  input  IDX_W  destination register index
instr_rs1  input  IDX_W  source A register index
instr_rs2  input  IDX_W  source B register index
bus_data  input  DATA_W  register bank read bus (tri-state, high-Z when bus_oe=0)
rd_index  output  IDX_W  register bank read select
bus_oe  output  1  register bank read output enable
wr_index  output  IDX_W  register bank write select (decoded by the bank; 0 = no write)
wr_data  output  DATA_W  register bank write data
done  output  1  one-cycle pulse, coincident with the write cycle
flags  output  3  {N,C,Z} of the last completed instruction

Behaviour:
- Reset values (async on RESET): state=IDLE, instr_ready=1, rd_index=0, bus_oe=0, wr_index=0, wr_data=0, done=0, flags=0. Internal A, B, result, op and rd latches = 0.
- IDLE:
  - instr_ready=1, bus_oe=0, wr_index=0.
  - On a rising edge with instr_valid=1, latch op/rd/rs1/rs2 and go to READ_A.
  - instr_ready is 0 in every other state; instr_valid is ignored outside IDLE.
- READ_A: rd_index=rs1, bus_oe=1; A <= bus_data at the closing edge; next READ_B.
- READ_B: rd_index=rs2, bus_oe=1; B <= bus_data at the closing edge; next EXEC.
- EXEC: bus_oe=0; result and new flags are registered at the closing edge; next WRITE.
- WRITE:
  - wr_index=rd and wr_data=result for exactly this cycle; done=1; flags updated.
  - Bank captures at the closing edge; next IDLE.
- Bus sampling: bus_data is sampled only in READ_A/READ_B. bus_oe is never high in IDLE, EXEC or WRITE.
- Timing: accept edge at cycle 0; READ_A cycle 1; READ_B cycle 2; EXEC cycle 3; WRITE cycle 4; next accept possible at the cycle 5 edge.
  - Sustained throughput is 1 instruction per 5 cycles.
- Opcodes (all arithmetic modulo 2^DATA_W):
  - 000 ADD: A+B; C = carry-out.
  - 001 SUB: A-B; C=1 when A>=B (no borrow).
  - 010 AND: C=0.
  - 011 OR: C=0.
  - 100 XOR: C=0.
  - 101 NOT A: C=0.
  - 110 SHL A by 1: C=A[MSB], LSB filled with 0.
  - 111 MOV A: C=0.
- Flags: Z = result==0; N = result[MSB].
- Boundary conditions:
  - rd=0: WRITE still occurs with wr_index=0, so the bank does not write; done still pulses and flags still update.
  - rs1 or rs2 = 0 reads 0.
  - rs1 = rs2 = rd is legal; the write lands after both reads.
  - Reset mid-instruction returns to IDLE immediately with all outputs at reset values. No partial write, because wr_index is forced to 0.
  - instr_valid held high continuously: a new instruction is accepted only in IDLE.

Test Plan:
- Reset, then preload bank r1=0x05, r2=0x03; ADD rd=3 rs1=1 rs2=2 -> wr_index=3, wr_data=0x08, done at cycle 4, flags {N,C,Z}=000, r3=0x08.
- r1=0xFF, r2=0x01, ADD rd=4 -> wr_data=0x00, flags=011 (C=1, Z=1). Then SUB rd=5 rs1=2 rs2=1 -> 0x02, C=0.
- SHL rd=6 rs1=1 (0x81) -> wr_data=0x02, C=1. Then MOV rd=0 rs1=1 -> wr_index=0 (no write), bank r0 stays 0x00, done pulses.
- Hold instr_valid=1 with back-to-back instructions -> instr_ready low for 4 cycles, accepts exactly every 5 cycles, and bus_oe is high only in cycles 1-2 of each instruction.
- Assert RESET during READ_B of an ADD -> all outputs 0 asynchronously, no bank register changes, next instruction executes normally from IDLE.
- Dependent pair: ADD r3=r1+r2 followed by SUB r4=r3-r1 -> the second instruction reads the updated r3 (r1=0x05, r2=0x03: r4=0x03).

Source files
------------

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: groups the sequencer's instruction handshake and the
// register-bank bus into one bundle.
//   master : sequencer side (accepts instructions, drives bank selects/data)
//   slave  : environment side (issues instructions, owns the bank)
// Signals:
//   instr_valid/instr_ready         instruction handshake
//   instr_op/instr_rd/rs1/rs2       opcode and register indices
//   bus_data                        bank read bus (valid only while bus_oe=1)
//   rd_index/bus_oe                 bank read select and output enable
//   wr_index/wr_data                bank write select (0 = no write) and data
//   done/flags                      completion pulse and {N,C,Z}
interface alu_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [IDX_W-1:0]  instr_rd;
  logic [IDX_W-1:0]  instr_rs1;
  logic [IDX_W-1:0]  instr_rs2;
  logic [DATA_W-1:0] bus_data;
  logic [IDX_W-1:0]  rd_index;
  logic              bus_oe;
  logic [IDX_W-1:0]  wr_index;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic [2:0]        flags;

  modport master (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, bus_data,
    output instr_ready, rd_index, bus_oe, wr_index, wr_data, done, flags
  );

  modport slave (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, bus_data,
    input  instr_ready, rd_index, bus_oe, wr_index, wr_data, done, flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: micro-sequencer/ALU in front of an 8-entry register bank.
// Runs one rd <= rs1 op rs2 instruction per accepted request through a fixed
// IDLE -> READ_A -> READ_B -> EXEC -> WRITE sequence (one instruction per
// 5 cycles sustained).
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous, active-high reset
//   bus    alu_sequencer_if.master (instruction handshake + bank bus)
// All bank-facing outputs are decoded from the state register, so an
// asynchronous reset forces wr_index to 0 at once and no partial write can
// reach the bank.
module alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic            CLK,
  input  logic            RESET,
  alu_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, READ_A, READ_B, EXEC, WRITE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic [IDX_W-1:0]  rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [2:0]        flags_q;
  logic [DATA_W:0]   exec_res;

  // Returns {carry, result}.
  function automatic logic [DATA_W:0] alu_eval(input logic [2:0]        op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    case (op)
      3'b000:  alu_eval = {1'b0, a} + {1'b0, b};
      3'b001:  alu_eval = {(a >= b), a - b};       // carry = no borrow
      3'b010:  alu_eval = {1'b0, a & b};
      3'b011:  alu_eval = {1'b0, a | b};
      3'b100:  alu_eval = {1'b0, a ^ b};
      3'b101:  alu_eval = {1'b0, ~a};
      3'b110:  alu_eval = {a[DATA_W-1], a[DATA_W-2:0], 1'b0};
      default: alu_eval = {1'b0, a};
    endcase
  endfunction

  always_comb exec_res = alu_eval(op_q, a_q, b_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.rd_index    = '0;
    bus.bus_oe      = 1'b0;
    bus.wr_index    = '0;
    bus.wr_data     = '0;
    bus.done        = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = READ_A;
      end
      READ_A: begin
        bus.rd_index = rs1_q;
        bus.bus_oe   = 1'b1;
        state_nxt    = READ_B;
      end
      READ_B: begin
        bus.rd_index = rs2_q;
        bus.bus_oe   = 1'b1;
        state_nxt    = EXEC;
      end
      EXEC: state_nxt = WRITE;
      WRITE: begin
        bus.wr_index = rd_q;
        bus.wr_data  = result_q;
        bus.done     = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.flags = flags_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q  <= bus.instr_op;
            rd_q  <= bus.instr_rd;
            rs1_q <= bus.instr_rs1;
            rs2_q <= bus.instr_rs2;
          end
        end
        READ_A: a_q <= bus.bus_data;
        READ_B: b_q <= bus.bus_data;
        EXEC: begin
          result_q <= exec_res[DATA_W-1:0];
          flags_q  <= {exec_res[DATA_W-1], exec_res[DATA_W],
                       (exec_res[DATA_W-1:0] == '0)};
        end
        default: ;
      endcase
    end
  end

endmodule
